// File: rtl/cas_sorter.sv
// Iterative odd-even transposition sorter: loads a packed vector, runs one
// compare-and-swap phase per cycle for NUM_INPUTS cycles, then holds the result.
module cas_sorter #(
  parameter int unsigned BITS       = 10,
  parameter int unsigned NUM_INPUTS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_INPUTS*BITS-1:0] in_data,
  input  logic                       order,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_INPUTS*BITS-1:0] out_data,
  output logic                       busy
);

  localparam int unsigned PW = $clog2(NUM_INPUTS) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                              state_q, state_d;
  logic [PW-1:0]                       phase_q, phase_d;
  logic                                order_q, order_d;
  logic [NUM_INPUTS-1:0][BITS-1:0]     work_q, work_d;
  logic [NUM_INPUTS-1:0][BITS-1:0]     cas_c;
  logic                                in_ready_q, in_ready_d;
  logic                                out_valid_q, out_valid_d;
  logic                                busy_q, busy_d;

  // One transposition phase: pairs starting at indices matching the phase parity.
  always_comb begin
    cas_c = work_q;
    for (int i = 0; i < int'(NUM_INPUTS) - 1; i++) begin
      if (1'(i) == phase_q[0]) begin
        if (order_q ? (work_q[i] > work_q[i+1]) : (work_q[i] < work_q[i+1])) begin
          cas_c[i]   = work_q[i+1];
          cas_c[i+1] = work_q[i];
        end
      end
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    order_d = order_q;
    work_d  = work_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          order_d = order;
          phase_d = '0;
          state_d = SORT;
        end
      end
      SORT: begin
        work_d  = cas_c;
        phase_d = phase_q + PW'(1);
        if (phase_q == PW'(NUM_INPUTS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d == SORT);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      order_q     <= 1'b0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      order_q     <= order_d;
      work_q      <= work_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = work_q;

endmodule
